// File: rtl/i2c_regmap_pkg.sv
// -----------------------------------------------------------------------------
// i2c_regmap_pkg
// Shared definitions for the I2C control register bank: register map size,
// pointer width, register address constants and the byte-phase encoding.
// -----------------------------------------------------------------------------
package i2c_regmap_pkg;

    localparam int NREG  = 16;
    localparam int PTR_W = 4;

    localparam logic [PTR_W-1:0] REG_FREQ0 = 4'd0;
    localparam logic [PTR_W-1:0] REG_FREQ1 = 4'd1;
    localparam logic [PTR_W-1:0] REG_FREQ2 = 4'd2;
    localparam logic [PTR_W-1:0] REG_FREQ3 = 4'd3;
    localparam logic [PTR_W-1:0] REG_GAIN  = 4'd4;
    localparam logic [PTR_W-1:0] REG_CTRL  = 4'd5;
    localparam logic [PTR_W-1:0] REG_ID    = 4'd15;

    // P_PTR: next written byte is a register pointer.
    // P_DATA: written bytes go to reg[ptr] with auto-increment.
    typedef enum logic {
        P_PTR  = 1'b0,
        P_DATA = 1'b1
    } phase_t;

endpackage

// File: rtl/i2c_reg_bank_if.sv
// -----------------------------------------------------------------------------
// i2c_reg_bank_if
// Byte-level handshake between the I2C slave byte engine (master modport)
// and the register bank (slave modport).
//   data_wrt  [7:0]  byte written by the I2C master
//   wrt_tick         one-cycle strobe, data_wrt valid
//   data_req         level, engine wants a read byte
//   data_rd   [7:0]  byte returned to the I2C master
//   rd_tick          one-cycle strobe, data_rd valid
// -----------------------------------------------------------------------------
interface i2c_reg_bank_if;
    logic [7:0] data_wrt;
    logic       wrt_tick;
    logic       data_req;
    logic [7:0] data_rd;
    logic       rd_tick;

    modport master (
        output data_wrt,
        output wrt_tick,
        output data_req,
        input  data_rd,
        input  rd_tick
    );

    modport slave (
        input  data_wrt,
        input  wrt_tick,
        input  data_req,
        output data_rd,
        output rd_tick
    );
endinterface

// File: rtl/i2c_bus_cond_detect.sv
// -----------------------------------------------------------------------------
// i2c_bus_cond_detect
// Synchronises the raw scl/sda lines into the clk domain and flags bus
// START (sda falls while scl high) and STOP (sda rises while scl high).
//   clk, reset   system clock, asynchronous active-high reset
//   scl, sda     raw I2C lines (monitor only)
//   start, stop  one-cycle pulses
// Pulses are decoded combinationally from the synchronised/delayed flops so
// that a pin change reaches a registered consumer 3 clocks later.
// -----------------------------------------------------------------------------
module i2c_bus_cond_detect (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic start,
    output logic stop
);

    logic scl_s1, scl_s2;
    logic sda_s1, sda_s2, sda_d;

    // Reset to the idle-high bus level so no condition is flagged out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign start = scl_s2 &  sda_d & ~sda_s2;
    assign stop  = scl_s2 & ~sda_d &  sda_s2;

endmodule

// File: rtl/i2c_reg_bank.sv
// -----------------------------------------------------------------------------
// i2c_reg_bank
// Turns the I2C slave byte stream into the receiver control registers.
// First written byte after START/STOP is the register pointer; following
// bytes are written with auto-increment. Register 3 write commits the
// 32-bit NCO frequency word atomically from the shadow registers 0..3.
//   clk, reset    system clock, asynchronous active-high reset
//   scl, sda      raw I2C lines, used only for START/STOP detection
//   bus           byte handshake (slave modport of i2c_reg_bank_if)
//   freq_word     committed NCO tuning word
//   freq_update   one-cycle pulse when freq_word is committed
//   gain, ctrl    registers 4 and 5
// Build option: I2C_REG_READBACK_EN -- when defined, reads return reg[ptr]
// and advance the pointer; when undefined, every read returns DEVICE_ID and
// the pointer is left untouched.
// -----------------------------------------------------------------------------
module i2c_reg_bank
    import i2c_regmap_pkg::*;
#(
    parameter logic [31:0] FREQ_RESET = 32'd0,
    parameter logic [7:0]  GAIN_RESET = 8'h00,
    parameter logic [7:0]  DEVICE_ID  = 8'hD9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl,
    input  logic                 sda,
    i2c_reg_bank_if.slave        bus,
    output logic [31:0]          freq_word,
    output logic                 freq_update,
    output logic [7:0]           gain,
    output logic [7:0]           ctrl
);

    logic             start, stop;
    logic             bus_cond;
    logic             req_rise;
    logic             data_req_q;
    phase_t           phase;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       regs [NREG];

    i2c_bus_cond_detect u_cond (
        .clk   (clk),
        .reset (reset),
        .scl   (scl),
        .sda   (sda),
        .start (start),
        .stop  (stop)
    );

    assign bus_cond = start | stop;
    assign req_rise = bus.data_req & ~data_req_q;

`ifdef I2C_REG_READBACK_EN
    // Register 15 is not stored; it always reads as the device ID.
    function automatic logic [7:0] read_byte(input logic [PTR_W-1:0] p);
        return (p == REG_ID) ? DEVICE_ID : regs[p];
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= P_PTR;
            ptr         <= '0;
            data_req_q  <= 1'b0;
            bus.data_rd <= 8'h00;
            bus.rd_tick <= 1'b0;
            freq_word   <= FREQ_RESET;
            freq_update <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 8'h00;
            end
            regs[REG_FREQ0] <= FREQ_RESET[7:0];
            regs[REG_FREQ1] <= FREQ_RESET[15:8];
            regs[REG_FREQ2] <= FREQ_RESET[23:16];
            regs[REG_FREQ3] <= FREQ_RESET[31:24];
            regs[REG_GAIN]  <= GAIN_RESET;
        end else begin
            data_req_q  <= bus.data_req;
            bus.rd_tick <= 1'b0;
            freq_update <= 1'b0;

            if (req_rise) begin
                bus.rd_tick <= 1'b1;
`ifdef I2C_REG_READBACK_EN
                bus.data_rd <= read_byte(ptr);
`else
                bus.data_rd <= DEVICE_ID;
`endif
            end

            if (bus.wrt_tick) begin
                if (phase == P_PTR) begin
                    ptr   <= bus.data_wrt[PTR_W-1:0];
                    phase <= P_DATA;
                end else begin
                    if (ptr != REG_ID) begin
                        regs[ptr] <= bus.data_wrt;
                    end
                    // Commit uses the incoming byte for bits 31:24, not the stale reg 3.
                    if (ptr == REG_FREQ3) begin
                        freq_word   <= {bus.data_wrt, regs[REG_FREQ2],
                                        regs[REG_FREQ1], regs[REG_FREQ0]};
                        freq_update <= 1'b1;
                    end
                    ptr <= ptr + 1'b1;
                end
            end
`ifdef I2C_REG_READBACK_EN
            else if (req_rise) begin
                ptr <= ptr + 1'b1;
            end
`endif

            // Placed last so a same-cycle write is applied before the phase reset.
            if (bus_cond) begin
                phase <= P_PTR;
            end
        end
    end

    assign gain = regs[REG_GAIN];
    assign ctrl = regs[REG_CTRL];

endmodule
